alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (req0: main datapath, req1: auxiliary/complex-op unit).
//  Round-robin arbitration, valid/ready handshakes, operand/result registering; one operation in flight.
//  Sits between the requesters and the ALU instance; drives ALU inputs, captures ALU result and carry flag.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W  5   immediate shift-amount width
//  OP_W     4   ALU opcode width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  req0_valid    in   1        req0 has an operation
//  req0_ready    out  1        req0 operation accepted this cycle
//  req0_in1      in   DATA_W   req0 operand 1
//  req0_in2      in   DATA_W   req0 operand 2
//  req0_shamt    in   SHAMT_W  req0 immediate shift amount
//  req0_op       in   OP_W     req0 ALU opcode
//  req1_*        --   --       same set as req0_*, for requester 1
//  rsp_valid     out  1        result available
//  rsp_ready     in   1        consumer accepts result
//  rsp_id        out  1        requester owning the result (0/1)
//  rsp_result    out  DATA_W   captured ALU result
//  rsp_flag      out  1        captured ALU flag (carry of add; 0 otherwise)
//  alu_in1/alu_in2/alu_shamt/alu_op  out  DATA_W/DATA_W/SHAMT_W/OP_W  to ALU
//  alu_out/alu_flag                  in   DATA_W/1                    from ALU
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> RESP -> IDLE. Reset: state IDLE, rr pointer=0 (req0 priority), all outputs 0.
//  IDLE: if any reqN_valid, grant = pointer side if valid, else other side; reqN_ready=1 (comb) for grantee only;
//   latch in1/in2/shamt/op and id on that edge; go EXEC. No valid -> stay IDLE, both readys 0.
//  EXEC: alu_* driven from latched registers (stable whole state); capture alu_out/alu_flag at edge; go RESP.
//  RESP: rsp_valid=1, rsp_id/result/flag held stable until rsp_valid&&rsp_ready; then IDLE, pointer = ~rsp_id.
//  Readys are 0 in EXEC and RESP. Accept->rsp_valid latency 2 cycles; max throughput 1 op / 3 cycles.
//  Requesters hold valid and operands until ready; dropping valid before ready is legal (no grant).
//  Opcode passed through unmodified, not decoded (op[3] selects shift source inside ALU).
//  alu_* outputs hold last latched values in IDLE (0 after reset).
//  Reset in any state: in-flight op discarded, no rsp_valid, pointer->0.
//  Simultaneous valids: pointer decides; alternation guaranteed under continuous contention.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: adds outputs grant_cnt0/grant_cnt1 (16 bit each) counting accepts per requester,
//   saturating at 16'hFFFF, cleared by rst. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Shared include alu_defs.vh: FSM state localparams (IDLE/EXEC/RESP), ALU opcode constants
//   (ADD 0000, CMPL 0001, AND 0010, XOR 0011, SLL 0100, SRL 0101, SRA 0110, DIFF 0111; +8 = shift by in2).
//  One sub-module: rr_arbiter_2 (pointer register + grant logic, update on completion).
// TESTING
//  Reset: rst high 2 cycles -> rsp_valid=0, both readys 0, alu_* =0, counters 0.
//  req0 ADD in1=32'hFFFFFFFF in2=1 -> req0_ready at T, rsp_valid at T+2, id0, result 0, flag 1.
//  Both valid from reset: req0 AND 32'hF0F0/32'h0FF0, req1 SLL in1=1 shamt=4 -> id0 32'h00F0, then id1 32'h10.
//  Continuous contention 6 ops -> grant order 0,1,0,1,0,1; grant_cnt0=grant_cnt1=3 with macro.
//  rsp_ready low 5 cycles in RESP -> rsp_* stable, readys 0, then single handshake; op 4'b1100 in1=1 in2=3 shamt=7 -> 32'h8.
//  rst asserted during EXEC -> no rsp_valid follows, next contention grants req0 first.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: widths, FSM state codes,
// ALU opcode constants and the request bundle type.
package alu_share_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALU opcodes; setting bit 3 makes shifts take their amount from in2
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_CMPL = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b0110;
  localparam logic [OP_W-1:0] OP_DIFF = 4'b0111;

  // One latched ALU operation
  typedef struct packed {
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
    logic [SHAMT_W-1:0] shamt;
    logic [OP_W-1:0]    op;
  } alu_req_t;

  // Saturating 16-bit increment for the grant statistics
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals of the arbiter.
// slave: the arbiter's view; master: the environment's view.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic               req0_valid, req0_ready;
  logic [DATA_W-1:0]  req0_in1, req0_in2;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [OP_W-1:0]    req0_op;

  logic               req1_valid, req1_ready;
  logic [DATA_W-1:0]  req1_in1, req1_in2;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [OP_W-1:0]    req1_op;

  logic               rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [DATA_W-1:0]  rsp_result;

  logic [DATA_W-1:0]  alu_in1, alu_in2, alu_out;
  logic [SHAMT_W-1:0] alu_shamt;
  logic [OP_W-1:0]    alu_op;
  logic               alu_flag;

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_shamt, req0_op,
    output req0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_shamt, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flag,
    input  rsp_ready,
    output alu_in1, alu_in2, alu_shamt, alu_op,
    input  alu_out, alu_flag
  );

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_shamt, req0_op,
    input  req0_ready,
    output req1_valid, req1_in1, req1_in2, req1_shamt, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flag,
    output rsp_ready,
    input  alu_in1, alu_in2, alu_shamt, alu_op,
    output alu_out, alu_flag
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: the pointer side wins when both request;
// the pointer moves to the other side when an operation completes.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic done_i,
  input  logic done_id_i,
  output logic grant0_o,
  output logic grant1_o
);

  logic ptr_q;

  // Pointer update on completion: the requester just served loses priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (done_i) begin
      ptr_q <= ~done_id_i;
    end
  end

  // Grant: pointer side if valid, otherwise the other side
  always_comb begin
    grant0_o = valid0_i & (~ptr_q | ~valid1_i);
    grant1_o = valid1_i & ( ptr_q | ~valid0_i);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a
// round-robin IDLE -> EXEC -> RESP sequence, one operation in flight.
// Optional: define ALU_ARB_STATS_EN to add saturating per-requester
// accept counters grant_cnt0_o / grant_cnt1_o.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt0_o,
  output logic [15:0]        grant_cnt1_o
`endif
);

  logic [1:0]        state_q, state_d;
  alu_req_t          req_q, req_sel;
  logic              id_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_q;
  logic              grant0, grant1, accept, done;

  assign done = (state_q == ST_RESP) && bus.rsp_ready;

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid0_i  (bus.req0_valid),
    .valid1_i  (bus.req1_valid),
    .done_i    (done),
    .done_id_i (id_q),
    .grant0_o  (grant0),
    .grant1_o  (grant1)
  );

  // Readys only while idle, and only to the arbitration winner
  always_comb begin
    bus.req0_ready = (state_q == ST_IDLE) && grant0;
    bus.req1_ready = (state_q == ST_IDLE) && grant1;
    accept         = bus.req0_ready || bus.req1_ready;
  end

  // Operand mux for the winning requester
  always_comb begin
    if (grant1) begin
      req_sel = '{in1: bus.req1_in1, in2: bus.req1_in2, shamt: bus.req1_shamt, op: bus.req1_op};
    end else begin
      req_sel = '{in1: bus.req0_in1, in2: bus.req0_in2, shamt: bus.req0_shamt, op: bus.req0_op};
    end
  end

  // Next-state logic of the single-op sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand latch on accept, ALU result capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_sel;
        id_q  <= grant1;
      end
      if (state_q == ST_EXEC) begin
        result_q <= bus.alu_out;
        flag_q   <= bus.alu_flag;
      end
    end
  end

  assign bus.alu_in1    = req_q.in1;
  assign bus.alu_in2    = req_q.in2;
  assign bus.alu_shamt  = req_q.shamt;
  assign bus.alu_op     = req_q.op;

  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flag   = flag_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating accept counters per requester
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (bus.req0_ready) cnt0_q <= sat_inc16(cnt0_q);
      if (bus.req1_ready) cnt1_q <= sat_inc16(cnt1_q);
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk, rst;
  alu_share_arbiter_if bus();
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1;
`endif

  alu_share_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0_o (gc0),
    .grant_cnt1_o (gc1)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct { bit id; logic [31:0] res; logic flag; } rsp_t;
  rsp_t resp_log[$];
  bit   grant_log[$];
  bit   rand_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: {flag, result}
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [3:0] op);
    logic [4:0]  s;
    logic [32:0] r;
    logic [2:0]  k;
    s = op[3] ? b[4:0] : sh;
    k = op[2:0];
    if (k == OP_ADD[2:0])       r = {1'b0, a} + {1'b0, b};
    else if (k == OP_CMPL[2:0]) r = {1'b0, ~a};
    else if (k == OP_AND[2:0])  r = {1'b0, a & b};
    else if (k == OP_XOR[2:0])  r = {1'b0, a ^ b};
    else if (k == OP_SLL[2:0])  r = {1'b0, a << s};
    else if (k == OP_SRL[2:0])  r = {1'b0, a >> s};
    else if (k == OP_SRA[2:0])  r = {1'b0, 32'($signed(a) >>> s)};
    else                        r = {1'b0, a - b};
    return r;
  endfunction

  always_comb {bus.alu_flag, bus.alu_out} = ref_alu(bus.alu_in1, bus.alu_in2, bus.alu_shamt, bus.alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, round-robin pointer, 2-cycle latency
  bit          m_busy, m_resp, m_ptr, m_id, m_flag;
  logic [31:0] m_in1, m_in2, m_res;
  logic [4:0]  m_sh;
  logic [3:0]  m_op;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] m_cnt0, m_cnt1;
`endif

  initial begin
    bit e0, e1;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_resp = 0; m_ptr = 0;
`ifdef ALU_ARB_STATS_EN
        m_cnt0 = 0; m_cnt1 = 0;
`endif
      end else begin
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", gc0, m_cnt0);
        chk("grant_cnt1", gc1, m_cnt1);
`endif
        if (!m_busy) begin
          e0 = bus.req0_valid && (!m_ptr || !bus.req1_valid);
          e1 = bus.req1_valid && ( m_ptr || !bus.req0_valid);
          chk("idle_ready0", bus.req0_ready, e0);
          chk("idle_ready1", bus.req1_ready, e1);
          chk("idle_rsp_valid", bus.rsp_valid, 0);
          if (e0 || e1) begin
            m_id  = e1;
            m_in1 = e1 ? bus.req1_in1 : bus.req0_in1;
            m_in2 = e1 ? bus.req1_in2 : bus.req0_in2;
            m_sh  = e1 ? bus.req1_shamt : bus.req0_shamt;
            m_op  = e1 ? bus.req1_op : bus.req0_op;
            {m_flag, m_res} = ref_alu(m_in1, m_in2, m_sh, m_op);
            grant_log.push_back(m_id);
`ifdef ALU_ARB_STATS_EN
            if (e0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 1;
            if (e1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 1;
`endif
            m_busy = 1; m_resp = 0;
          end
        end else if (!m_resp) begin
          chk("exec_ready0", bus.req0_ready, 0);
          chk("exec_ready1", bus.req1_ready, 0);
          chk("exec_rsp_valid", bus.rsp_valid, 0);
          chk("exec_alu_in1", bus.alu_in1, m_in1);
          chk("exec_alu_in2", bus.alu_in2, m_in2);
          chk("exec_alu_shamt", bus.alu_shamt, m_sh);
          chk("exec_alu_op", bus.alu_op, m_op);
          m_resp = 1;
        end else begin
          chk("resp_ready0", bus.req0_ready, 0);
          chk("resp_ready1", bus.req1_ready, 0);
          chk("resp_valid", bus.rsp_valid, 1);
          chk("resp_id", bus.rsp_id, m_id);
          chk("resp_result", bus.rsp_result, m_res);
          chk("resp_flag", bus.rsp_flag, m_flag);
          if (bus.rsp_ready) begin
            resp_log.push_back('{id: bus.rsp_id, res: bus.rsp_result, flag: bus.rsp_flag});
            $display("rsp id=%0d op=%h result=%h flag=%0d", bus.rsp_id, m_op, bus.rsp_result, bus.rsp_flag);
            m_busy = 0;
            m_ptr  = ~m_id;
          end
        end
      end
    end
  end

  task automatic do_reset();
    bus.req0_valid = 0; bus.req1_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Present one op and hold it until accepted (or dropped after max_wait cycles)
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [3:0] op, input int max_wait,
                      input bit may_drop, output bit accepted, output int waited);
    accepted = 0;
    waited   = max_wait;
    if (!id) begin
      bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_shamt = sh; bus.req0_op = op; bus.req0_valid = 1;
    end else begin
      bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_shamt = sh; bus.req1_op = op; bus.req1_valid = 1;
    end
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if ((!id && bus.req0_ready) || (id && bus.req1_ready)) begin
        accepted = 1;
        waited   = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!id) bus.req0_valid = 0; else bus.req1_valid = 0;
    if (!may_drop) chk("send_accept_timeout", accepted, 1);
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 200; i++) begin
      if (resp_log.size() >= n) break;
      @(posedge clk);
      #1;
    end
    chk("wait_resp_count", resp_log.size() >= n, 1);
  endtask

  task automatic rand_req(input bit id, input int n);
    bit ok;
    int w;
    bit drop;
    logic [31:0] a, b;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      b    = ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom();
      drop = ($urandom_range(0, 3) == 0);
      send(id, a, b, 5'($urandom()), 4'($urandom()), drop ? $urandom_range(1, 3) : 60, drop, ok, w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    int w, base, n;
    rst = 1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    bus.req0_in1 = 0; bus.req0_in2 = 0; bus.req0_shamt = 0; bus.req0_op = 0;
    bus.req1_in1 = 0; bus.req1_in2 = 0; bus.req1_shamt = 0; bus.req1_op = 0;

    // Reset values
    do_reset();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_gc0", gc0, 0);
    chk("rst_gc1", gc1, 0);
`endif

    // ADD with carry out: ready at T, response at T+2
    bus.rsp_ready = 1;
    send(0, 32'hFFFF_FFFF, 32'h1, 5'd0, OP_ADD, 10, 0, ok, w);
    chk("add_ready_first_cycle", w, 0);
    chk("add_t1_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    chk("add_t2_rsp_valid", bus.rsp_valid, 1);
    chk("add_id", bus.rsp_id, 0);
    chk("add_result", bus.rsp_result, 32'h0);
    chk("add_flag", bus.rsp_flag, 1);
    @(posedge clk); #1;

    // Both valid from reset: req0 first, then req1
    do_reset();
    n = resp_log.size();
    fork
      begin bit o0; int w0; send(0, 32'hF0F0, 32'h0FF0, 5'd0, OP_AND, 20, 0, o0, w0); end
      begin bit o1; int w1; send(1, 32'h1, 32'h0, 5'd4, OP_SLL, 20, 0, o1, w1); end
    join
    wait_resp(n + 2);
    chk("both_first_id", resp_log[n].id, 0);
    chk("both_first_res", resp_log[n].res, 32'h00F0);
    chk("both_second_id", resp_log[n+1].id, 1);
    chk("both_second_res", resp_log[n+1].res, 32'h10);

    // Continuous contention: strict alternation
    do_reset();
    base = grant_log.size();
    n = resp_log.size();
    fork
      begin bit o0; int w0; repeat (3) send(0, $urandom(), $urandom(), 5'd1, OP_XOR, 20, 0, o0, w0); end
      begin bit o1; int w1; repeat (3) send(1, $urandom(), $urandom(), 5'd2, OP_DIFF, 20, 0, o1, w1); end
    join
    wait_resp(n + 6);
    chk("contention_grants", grant_log.size() - base, 6);
    if (grant_log.size() >= base + 6)
      for (int k = 0; k < 6; k++) chk($sformatf("contention_order_%0d", k), grant_log[base+k], k % 2);
`ifdef ALU_ARB_STATS_EN
    chk("contention_gc0", gc0, 3);
    chk("contention_gc1", gc1, 3);
`endif

    // Back-pressure: rsp held stable 5 cycles, single handshake
    bus.rsp_ready = 0;
    send(0, 32'h1, 32'h3, 5'd7, 4'b1100, 10, 0, ok, w);
    bus.req1_in1 = 32'h5; bus.req1_in2 = 32'h6; bus.req1_shamt = 0; bus.req1_op = OP_XOR;
    bus.req1_valid = 1;
    @(posedge clk); #1;
    n = resp_log.size();
    repeat (5) begin
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_id", bus.rsp_id, 0);
      chk("stall_result", bus.rsp_result, 32'h8);
      chk("stall_flag", bus.rsp_flag, 0);
      chk("stall_ready0", bus.req0_ready, 0);
      chk("stall_ready1", bus.req1_ready, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    chk("stall_one_handshake", resp_log.size(), n + 1);
    chk("stall_next_ready1", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    @(posedge clk); #1;
    chk("stall_second_held", resp_log.size(), n + 1);
    bus.rsp_ready = 1;
    wait_resp(n + 2);
    chk("stall_second_id", resp_log[n+1].id, 1);
    chk("stall_second_res", resp_log[n+1].res, 32'h3);

    // Reset during EXEC discards the op and restores req0 priority
    send(0, 32'h5, 32'h6, 5'd0, OP_AND, 10, 0, ok, w);
    wait_resp(n + 3);
    send(0, 32'h7, 32'h8, 5'd0, OP_ADD, 10, 0, ok, w);
    n = resp_log.size();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("exec_rst_alu_in1", bus.alu_in1, 0);
    chk("exec_rst_rsp_valid", bus.rsp_valid, 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("exec_rst_no_rsp", resp_log.size(), n);
    base = grant_log.size();
    fork
      begin bit o0; int w0; send(0, 32'h9, 32'h1, 5'd0, OP_ADD, 20, 0, o0, w0); end
      begin bit o1; int w1; send(1, 32'h9, 32'h1, 5'd0, OP_DIFF, 20, 0, o1, w1); end
    join
    wait_resp(n + 2);
    chk("exec_rst_first_grant", grant_log.size() > base ? grant_log[base] : 1'b1, 0);

    // Randomized traffic with random back-pressure and abandoned requests
    rand_done = 0;
    fork
      begin
        fork
          rand_req(0, 150);
          rand_req(1, 150);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1;
    repeat (10) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
